// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory-access stage: instruction class codes, FSM state
// encodings, the default timeout, and small decode helpers.
package mem_access_stage_pkg;

  // Instruction class codes, identical to the shared riscv_defs encodings
  localparam logic [2:0] R_TYPE = 3'd0;
  localparam logic [2:0] I_TYPE = 3'd1;
  localparam logic [2:0] S_TYPE = 3'd2;
  localparam logic [2:0] L_TYPE = 3'd3;
  localparam logic [2:0] B_TYPE = 3'd4;
  localparam logic [2:0] J_TYPE = 3'd5;
  localparam logic [2:0] U_TYPE = 3'd6;

  typedef enum logic {
    MemIdle = 1'b0,
    MemBusy = 1'b1
  } mem_state_e;

  localparam int unsigned DEFAULT_TIMEOUT = 64;

  function automatic logic is_mem_type(input logic [2:0] t);
    return (t == L_TYPE) || (t == S_TYPE);
  endfunction

  // Register-file write enable for a pass-through instruction
  function automatic logic writes_rd(input logic [2:0] t, input logic [4:0] rd);
    return (t != B_TYPE) && (rd != 5'd0);
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Request/acknowledge data-memory bus between the memory-access stage (master) and the
// data memory (slave).
interface mem_access_stage_if #(
  parameter int unsigned AddrW = 16
) ();
  logic             mem_req;
  logic             mem_we;
  logic [AddrW-1:0] mem_addr;
  logic [31:0]      mem_wdata;
  logic             mem_ack;
  logic [31:0]      mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_timeout_ctr.sv
// Saturating wait counter for outstanding memory requests; expire_o flags the last
// permitted BUSY cycle (count == TimeoutCycles-1). TimeoutCycles must be >= 2.
module mem_timeout_ctr #(
  parameter int unsigned TimeoutCycles = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CntW = $clog2(TimeoutCycles);
  localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles - 1);

  logic [CntW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == CntMax);

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: passes ALU results to writeback and performs word loads and
// stores over a req/ack bus. Define MISALIGN_TRAP_EN to trap misaligned loads/stores.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          in_type,
  input  logic [31:0]         in_alu_out,
  input  logic [31:0]         in_store_data,
  input  logic [4:0]          in_rd,
  mem_access_stage_if.master  mem,
  output logic                wb_valid,
  output logic                wb_we,
  output logic [4:0]          wb_rd,
  output logic [31:0]         wb_data,
  output logic                err
);

  mem_state_e state_d, state_q;

  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [31:0]       wdata_d, wdata_q;
  logic [4:0]        rd_d, rd_q;
  logic              store_d, store_q;

  logic              wb_valid_d, wb_valid_q;
  logic              wb_we_d, wb_we_q;
  logic [4:0]        wb_rd_d, wb_rd_q;
  logic [31:0]       wb_data_d, wb_data_q;
  logic              err_d, err_q;

  logic              ctr_clear, ctr_en, ctr_expire;
  logic              misalign;

`ifdef MISALIGN_TRAP_EN
  assign misalign = (in_alu_out[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  mem_timeout_ctr #(
    .TimeoutCycles (TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (ctr_clear),
    .en_i     (ctr_en),
    .expire_o (ctr_expire)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    store_d    = store_q;
    wb_valid_d = 1'b0;
    wb_we_d    = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    err_d      = 1'b0;
    ctr_clear  = 1'b0;
    ctr_en     = 1'b0;

    unique case (state_q)
      MemIdle: begin
        if (in_valid) begin
          if (!is_mem_type(in_type)) begin
            wb_valid_d = 1'b1;
            wb_we_d    = writes_rd(in_type, in_rd);
            wb_rd_d    = in_rd;
            wb_data_d  = in_alu_out;
          end else if (misalign) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = in_rd;
            wb_data_d  = in_alu_out;
            err_d      = 1'b1;
          end else begin
            addr_d    = in_alu_out[ADDR_W+1:2];
            wdata_d   = in_store_data;
            rd_d      = in_rd;
            store_d   = (in_type == S_TYPE);
            ctr_clear = 1'b1;
            state_d   = MemBusy;
          end
        end
      end
      MemBusy: begin
        ctr_en = 1'b1;
        // Ack takes priority over an expiry in the same cycle
        if (mem.mem_ack) begin
          state_d    = MemIdle;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_we_d    = !store_q && (rd_q != 5'd0);
          wb_data_d  = store_q ? 32'd0 : mem.mem_rdata;
        end else if (ctr_expire) begin
          state_d    = MemIdle;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_data_d  = 32'd0;
          err_d      = 1'b1;
        end
      end
      default: state_d = MemIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= MemIdle;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      store_q    <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      store_q    <= store_d;
      wb_valid_q <= wb_valid_d;
      wb_we_q    <= wb_we_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      err_q      <= err_d;
    end
  end

  // Request outputs derive from state so an async reset drops mem_req at once
  assign in_ready      = (state_q == MemIdle);
  assign mem.mem_req   = (state_q == MemBusy);
  assign mem.mem_we    = (state_q == MemBusy) && store_q;
  assign mem.mem_addr  = (state_q == MemBusy) ? addr_q : '0;
  assign mem.mem_wdata = (state_q == MemBusy) ? wdata_q : '0;

  assign wb_valid = wb_valid_q;
  assign wb_we    = wb_we_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;
  assign err      = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage, built with a 4-cycle timeout.
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  localparam int unsigned AW = 16;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_type;
  logic [31:0] in_alu_out;
  logic [31:0] in_store_data;
  logic [4:0]  in_rd;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        err;

  int errors = 0;
  int checks = 0;

  mem_access_stage_if #(.AddrW(AW)) mem_if ();

  mem_access_stage #(
    .ADDR_W         (AW),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_type       (in_type),
    .in_alu_out    (in_alu_out),
    .in_store_data (in_store_data),
    .in_rd         (in_rd),
    .mem           (mem_if.master),
    .wb_valid      (wb_valid),
    .wb_we         (wb_we),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] t, input logic [31:0] alu, input logic [31:0] sd,
                       input logic [4:0] rd);
    in_valid      = 1'b1;
    in_type       = t;
    in_alu_out    = alu;
    in_store_data = sd;
    in_rd         = rd;
  endtask

  initial begin
    rst_n            = 1'b0;
    in_valid         = 1'b0;
    in_type          = R_TYPE;
    in_alu_out       = '0;
    in_store_data    = '0;
    in_rd            = '0;
    mem_if.mem_ack   = 1'b0;
    mem_if.mem_rdata = '0;

    tick();
    tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_mem_req", mem_if.mem_req, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_wb_we", wb_we, 0);
    rst_n = 1'b1;

    // Pass-through, back to back
    issue(R_TYPE, 32'h0000_002A, 32'h0, 5'd5);
    tick();
    chk("r_wb_valid", wb_valid, 1);
    chk("r_wb_we", wb_we, 1);
    chk("r_wb_rd", wb_rd, 5);
    chk("r_wb_data", wb_data, 32'h2A);
    chk("r_in_ready", in_ready, 1);
    issue(I_TYPE, 32'h0000_0055, 32'h0, 5'd0);
    tick();
    chk("rd0_wb_valid", wb_valid, 1);
    chk("rd0_wb_we", wb_we, 0);
    chk("rd0_wb_data", wb_data, 32'h55);
    issue(B_TYPE, 32'h0000_0007, 32'h0, 5'd3);
    tick();
    chk("b_wb_valid", wb_valid, 1);
    chk("b_wb_we", wb_we, 0);
    in_valid = 1'b0;
    tick();
    chk("idle_wb_valid", wb_valid, 0);
    chk("idle_wb_data_hold", wb_data, 32'h7);

    // Load acked in the third BUSY cycle
    issue(L_TYPE, 32'h0000_0010, 32'h0, 5'd7);
    tick();
    in_valid = 1'b0;
    chk("ld_in_ready", in_ready, 0);
    chk("ld_mem_req", mem_if.mem_req, 1);
    chk("ld_mem_we", mem_if.mem_we, 0);
    chk("ld_mem_addr", 32'(mem_if.mem_addr), 4);
    chk("ld_busy_wb_valid", wb_valid, 0);
    tick();
    tick();
    chk("ld_req_held", mem_if.mem_req, 1);
    mem_if.mem_ack   = 1'b1;
    mem_if.mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_if.mem_ack = 1'b0;
    chk("ld_wb_valid", wb_valid, 1);
    chk("ld_wb_we", wb_we, 1);
    chk("ld_wb_data", wb_data, 32'hDEAD_BEEF);
    chk("ld_wb_rd", wb_rd, 7);
    chk("ld_req_drop", mem_if.mem_req, 0);
    chk("ld_err", err, 0);
    chk("ld_in_ready_back", in_ready, 1);
    tick();
    chk("ld_wb_pulse", wb_valid, 0);

    // Store; wdata must stay latched while upstream data changes
    issue(S_TYPE, 32'h0000_0020, 32'h0000_1234, 5'd9);
    tick();
    in_valid      = 1'b0;
    in_store_data = 32'hFFFF_FFFF;
    chk("st_mem_we", mem_if.mem_we, 1);
    chk("st_mem_addr", 32'(mem_if.mem_addr), 8);
    chk("st_mem_wdata", mem_if.mem_wdata, 32'h1234);
    tick();
    chk("st_wdata_held", mem_if.mem_wdata, 32'h1234);
    chk("st_addr_held", 32'(mem_if.mem_addr), 8);
    mem_if.mem_ack = 1'b1;
    tick();
    mem_if.mem_ack = 1'b0;
    chk("st_wb_valid", wb_valid, 1);
    chk("st_wb_we", wb_we, 0);
    chk("st_wb_data", wb_data, 0);
    chk("st_req_drop", mem_if.mem_req, 0);

    // Load with no ack: 4 BUSY cycles then err beat; late ack ignored
    issue(L_TYPE, 32'h0000_0040, 32'h0, 5'd3);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("to_req_last_busy", mem_if.mem_req, 1);
    chk("to_err_early", err, 0);
    tick();
    chk("to_err", err, 1);
    chk("to_wb_valid", wb_valid, 1);
    chk("to_wb_we", wb_we, 0);
    chk("to_req_drop", mem_if.mem_req, 0);
    mem_if.mem_ack   = 1'b1;
    mem_if.mem_rdata = 32'h0BAD_0BAD;
    tick();
    mem_if.mem_ack = 1'b0;
    chk("late_ack_err", err, 0);
    chk("late_ack_wb_valid", wb_valid, 0);
    chk("late_ack_req", mem_if.mem_req, 0);
    chk("late_ack_ready", in_ready, 1);

    // Ack in the expiring cycle wins
    issue(L_TYPE, 32'h0000_0044, 32'h0, 5'd4);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    mem_if.mem_ack   = 1'b1;
    mem_if.mem_rdata = 32'hCAFE_0001;
    tick();
    mem_if.mem_ack = 1'b0;
    chk("race_err", err, 0);
    chk("race_wb_we", wb_we, 1);
    chk("race_wb_data", wb_data, 32'hCAFE_0001);

    // Async reset mid-BUSY
    issue(L_TYPE, 32'h0000_0080, 32'h0, 5'd6);
    tick();
    in_valid = 1'b0;
    chk("rst_busy_req", mem_if.mem_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_req", mem_if.mem_req, 0);
    chk("async_rst_ready", in_ready, 1);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_abort_wb", wb_valid, 0);
    chk("rst_abort_req", mem_if.mem_req, 0);

    // Misaligned load at 0x11
    issue(L_TYPE, 32'h0000_0011, 32'h0, 5'd2);
    tick();
    in_valid = 1'b0;
`ifdef MISALIGN_TRAP_EN
    chk("mis_req", mem_if.mem_req, 0);
    chk("mis_err", err, 1);
    chk("mis_wb_valid", wb_valid, 1);
    chk("mis_wb_we", wb_we, 0);
    chk("mis_ready", in_ready, 1);
`else
    chk("mis_req", mem_if.mem_req, 1);
    chk("mis_addr", 32'(mem_if.mem_addr), 4);
    mem_if.mem_ack   = 1'b1;
    mem_if.mem_rdata = 32'h1111_2222;
    tick();
    mem_if.mem_ack = 1'b0;
    chk("mis_err", err, 0);
    chk("mis_wb_data", wb_data, 32'h1111_2222);
`endif
    tick();
    chk("final_err", err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
